// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined) into a one-entry valid/ready holding register.
// Byte appears one cycle after the stop sample; a full, unconsumed holding register drops the new byte and pulses o_overrun.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [CW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   half_tick, full_tick;
  logic                   byte_done, frame_err_c;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  // All flops reset to 1 so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], uart_rx};
  end
  assign rx_s = sync[SYNC_STAGES-1];

  assign half_tick = (baud_cnt == HALF_M1);
  assign full_tick = (baud_cnt == FULL_M1);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    byte_done   = 1'b0;
    frame_err_c = 1'b0;
    unique case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (half_tick) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (full_tick && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (full_tick) state_next = STOP;
`else
      DATA:  if (full_tick && bit_cnt == 3'd7) state_next = STOP;
`endif
      STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_next  = BRK;
          end
        end
      end
      BRK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change, so each state measures from its own entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (state_next != state || state == IDLE || state == BRK) begin
      baud_cnt <= '0;
    end else if (full_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (state != DATA) begin
      bit_cnt <= 3'd0;
    end else if (full_tick) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= {rx_s, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                          par_bit <= 1'b0;
    else if (state == PARITY && full_tick) par_bit <= rx_s;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data       <= 8'h00;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= frame_err_c;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      if (o_valid && i_ready) o_valid <= 1'b0;
      // A consume in the completion cycle frees the slot for the new byte.
      if (byte_done) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          o_parity_err <= ^{shreg, par_bit};
`endif
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit; parity tests run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_CYC = PAR_EN ? 11 * CPB : 10 * CPB;
  // busy rises at t0+1, valid at t0 + CPB/2 + (stop slot)*CPB + 1
  localparam int LAT = PAR_EN ? (CPB / 2 + 10 * CPB) : (CPB / 2 + 9 * CPB);

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int fails  = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole writer of the observation counters and logs.
  int         busy_rise_cyc = 0;
  int         busy_cycles   = 0;
  int         valid_cycles  = 0;
  int         fe_cnt        = 0;
  int         ov_cnt        = 0;
  int         pe_cnt        = 0;
  int         multi_cnt     = 0;
  logic       prev_valid    = 1'b0;
  logic       prev_busy     = 1'b0;
  logic [7:0] rx_log[$];
  int         rise_log[$];

  always @(negedge clk) begin
    logic pe;
    pe = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe = o_parity_err;
`endif
    if (o_valid && !prev_valid) begin
      rx_log.push_back(o_data);
      rise_log.push_back(cyc);
    end
    if (o_busy && !prev_busy) busy_rise_cyc = cyc;
    if (o_busy)      busy_cycles++;
    if (o_valid)     valid_cycles++;
    if (o_frame_err) fe_cnt++;
    if (o_overrun)   ov_cnt++;
    if (pe)          pe_cnt++;
    if ((int'(o_frame_err) + int'(o_overrun) + int'(pe)) > 1) multi_cnt++;
    prev_valid = o_valid;
    prev_busy  = o_busy;
  end

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; uart_rx = 1'b1; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b busy=%b data=%h fe=%b ov=%b, want all 0", o_valid, o_busy, o_data, o_frame_err, o_overrun);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_basic;
    int n0, vc0, fe0, ov0, pe0;
    i_ready = 1'b1;
    n0 = rx_log.size(); vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 1 || rx_log[n0] !== 8'hA5) begin
      fails++;
      $display("FAIL basic_data: got %0d bytes first=%h, want 1 byte a5", rx_log.size() - n0, (rx_log.size() > n0) ? rx_log[n0] : 8'hxx);
    end else begin
      checks++;
      if (rise_log[n0] - busy_rise_cyc != LAT) begin
        fails++;
        $display("FAIL basic_latency: got %0d cycles busy->valid, want %0d", rise_log[n0] - busy_rise_cyc, LAT);
      end
    end
    checks++;
    if (valid_cycles - vc0 != 1) begin
      fails++;
      $display("FAIL basic_valid_width: got %0d cycles, want 1", valid_cycles - vc0);
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0) begin
      fails++;
      $display("FAIL basic_no_pulses: got fe=%0d ov=%0d pe=%0d, want 0 0 0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
    end
  endtask

  task automatic test_overrun;
    int ov0;
    i_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      fails++;
      $display("FAIL ovr_first: got valid=%b data=%h, want 1 3c", o_valid, o_data);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      fails++;
      $display("FAIL ovr_retained: got valid=%b data=%h, want 1 3c", o_valid, o_data);
    end
    checks++;
    if (ov_cnt - ov0 != 1) begin
      fails++;
      $display("FAIL ovr_pulse: got %0d pulses, want 1", ov_cnt - ov0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_drain: got valid=%b after handshake, want 0", o_valid);
    end
  endtask

  task automatic test_glitch;
    int bc0, n0, fe0, ov0;
    bc0 = busy_cycles; n0 = rx_log.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy_cycles - bc0 != CPB / 2) begin
      fails++;
      $display("FAIL glitch_busy_len: got %0d busy cycles, want %0d", busy_cycles - bc0, CPB / 2);
    end
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || rx_log.size() != n0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      fails++;
      $display("FAIL glitch_quiet: got busy=%b valid=%b bytes=%0d fe=%0d ov=%0d, want all 0", o_busy, o_valid, rx_log.size() - n0, fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_err;
    int n0, fe0;
    i_ready = 1'b1;
    n0 = rx_log.size(); fe0 = fe_cnt;
    send_frame(8'h55, ^8'h55, 1'b0);
    uart_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL break_busy: got busy=%b while line held low, want 1", o_busy);
    end
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (fe_cnt - fe0 != 1 || rx_log.size() != n0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_err: got fe=%0d bytes=%0d busy=%b, want 1 0 0", fe_cnt - fe0, rx_log.size() - n0, o_busy);
    end
    send_frame(8'h12, ^8'h12, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 1 || rx_log[rx_log.size() - 1] !== 8'h12 || fe_cnt - fe0 != 1) begin
      fails++;
      $display("FAIL after_break: got bytes=%0d last=%h fe=%0d, want 1 12 1", rx_log.size() - n0, (rx_log.size() > 0) ? rx_log[rx_log.size() - 1] : 8'hxx, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    i_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_data !== 8'h00 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
        fails++;
        $display("FAIL midreset_outputs: got busy=%b valid=%b data=%h fe=%b ov=%b, want all 0", o_busy, o_valid, o_data, o_frame_err, o_overrun);
      end
    end
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n0 = rx_log.size();
    send_frame(8'hF0, ^8'hF0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 1 || rx_log[rx_log.size() - 1] !== 8'hF0) begin
      fails++;
      $display("FAIL midreset_recover: got bytes=%0d last=%h, want 1 f0", rx_log.size() - n0, (rx_log.size() > 0) ? rx_log[rx_log.size() - 1] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    i_ready = 1'b1;
    n0 = rx_log.size();
    send_frame(8'h5A, ^8'h5A, 1'b1);
    send_frame(8'hC3, ^8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d bytes, want 2", rx_log.size() - n0);
    end else begin
      checks++;
      if (rx_log[n0] !== 8'h5A || rx_log[n0 + 1] !== 8'hC3) begin
        fails++;
        $display("FAIL b2b_data: got %h %h, want 5a c3", rx_log[n0], rx_log[n0 + 1]);
      end
      checks++;
      if (rise_log[n0 + 1] - rise_log[n0] != FRAME_CYC) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d cycles, want %0d", rise_log[n0 + 1] - rise_log[n0], FRAME_CYC);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, pe0;
    i_ready = 1'b1;
    n0 = rx_log.size(); pe0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 1 || rx_log[rx_log.size() - 1] !== 8'h07 || pe_cnt - pe0 != 1) begin
      fails++;
      $display("FAIL parity_bad: got bytes=%0d pe=%0d, want 1 1 with data 07", rx_log.size() - n0, pe_cnt - pe0);
    end
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() != n0 + 2 || rx_log[rx_log.size() - 1] !== 8'h07 || pe_cnt != pe0) begin
      fails++;
      $display("FAIL parity_good: got bytes=%0d pe=%0d, want 2 0 with data 07", rx_log.size() - n0, pe_cnt - pe0);
    end
  endtask
`endif

  task automatic test_pulse_exclusive;
    checks++;
    if (multi_cnt != 0) begin
      fails++;
      $display("FAIL pulse_exclusive: got %0d cycles with coincident pulses, want 0", multi_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
